// File: rtl/ntt_pkg.sv
// Shared constants and the digit-sum bank hash for the radix-16 NTT write-back path.
package ntt_pkg;

  localparam int BANKS       = 16;
  localparam int LANE_W      = 4;
  localparam int D_WIDTH_DEF = 12;
  localparam int ORD_MAX     = 64;

  // Zero-extension leaves the digit sum unchanged, so one width serves every D_WIDTH.
  function automatic logic [LANE_W-1:0] bank_of(input logic [ORD_MAX-1:0] order);
    logic [LANE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ORD_MAX / LANE_W; i++) begin
      acc = acc + order[i*LANE_W +: LANE_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/ntt_bank_map.sv
// Combinational lane-to-bank routing: digit-sum bank per lane, then a per-bank
// priority pick of the lowest matching lane.
module ntt_bank_map
  import ntt_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic [BANKS*D_WIDTH-1:0]          ord,
  output logic [BANKS*(D_WIDTH-LANE_W)-1:0] addr,
  output logic [BANKS*LANE_W-1:0]           sel,
  output logic                              conflict
);

  localparam int AW = D_WIDTH - LANE_W;

  logic [LANE_W-1:0] lane_bank [BANKS];
  logic [BANKS-1:0]  used;

  always_comb begin
    for (int k = 0; k < BANKS; k++) begin
      lane_bank[k] = bank_of(ORD_MAX'(ord[k*D_WIDTH +: D_WIDTH]));
    end
  end

  always_comb begin
    used     = '0;
    conflict = 1'b0;
    for (int k = 0; k < BANKS; k++) begin
      if (used[lane_bank[k]]) conflict = 1'b1;
      used[lane_bank[k]] = 1'b1;
    end
  end

  // Scan lanes high to low so the lowest matching lane is the last, winning assignment.
  always_comb begin
    addr = '0;
    sel  = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int k = BANKS - 1; k >= 0; k--) begin
        if (lane_bank[k] == LANE_W'(b)) begin
          sel[b*LANE_W +: LANE_W] = LANE_W'(k);
          addr[b*AW +: AW]        = ord[k*D_WIDTH + LANE_W +: AW];
        end
      end
    end
  end

endmodule

// File: rtl/ntt_wb_mapper.sv
// Write-back mapper: registers the bank mapping in M1, then delays write commands
// by the PE pipeline latency (PE_LAT in 2..32, D_WIDTH a multiple of 4).
module ntt_wb_mapper
  import ntt_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int PE_LAT  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ord_valid,
  input  logic [BANKS*D_WIDTH-1:0]          ord,
  input  logic [2:0]                        stage_in,
  input  logic                              agu_done,
  output logic                              wb_valid,
  output logic [BANKS*(D_WIDTH-LANE_W)-1:0] wb_addr,
  output logic [BANKS*LANE_W-1:0]           wb_sel,
  output logic [2:0]                        wb_stage,
  output logic                              wb_done,
  output logic                              busy,
  output logic                              map_err
);

  localparam int AW = D_WIDTH - LANE_W;
  localparam int SW = BANKS * LANE_W;

  logic [BANKS*AW-1:0] map_addr;
  logic [SW-1:0]       map_sel;
  logic                map_conflict;

  ntt_bank_map #(.D_WIDTH(D_WIDTH)) u_map (
    .ord      (ord),
    .addr     (map_addr),
    .sel      (map_sel),
    .conflict (map_conflict)
  );

  // Index 0 is the M1 register; indices 1..PE_LAT-1 form the delay line.
  logic                pipe_valid [PE_LAT];
  logic                pipe_done  [PE_LAT];
  logic [BANKS*AW-1:0] pipe_addr  [PE_LAT];
  logic [SW-1:0]       pipe_sel   [PE_LAT];
  logic [2:0]          pipe_stage [PE_LAT];
  logic [5:0]          cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid[0] <= 1'b0;
      pipe_done[0]  <= 1'b0;
      pipe_addr[0]  <= '0;
      pipe_sel[0]   <= '0;
      pipe_stage[0] <= '0;
    end else begin
      pipe_valid[0] <= ord_valid;
      pipe_done[0]  <= agu_done;
      pipe_addr[0]  <= map_addr;
      pipe_sel[0]   <= map_sel;
      pipe_stage[0] <= stage_in;
    end
  end

  for (genvar i = 1; i < PE_LAT; i++) begin : g_dly
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_valid[i] <= 1'b0;
        pipe_done[i]  <= 1'b0;
        pipe_addr[i]  <= '0;
        pipe_sel[i]   <= '0;
        pipe_stage[i] <= '0;
      end else begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_done[i]  <= pipe_done[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
        pipe_sel[i]   <= pipe_sel[i-1];
        pipe_stage[i] <= pipe_stage[i-1];
      end
    end
  end

  assign wb_valid = pipe_valid[PE_LAT-1];
  assign wb_done  = pipe_done[PE_LAT-1];
  assign wb_addr  = pipe_addr[PE_LAT-1];
  assign wb_sel   = pipe_sel[PE_LAT-1];
  assign wb_stage = pipe_stage[PE_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({ord_valid, wb_valid})
        2'b10:   cnt <= cnt + 6'd1;
        2'b01:   cnt <= cnt - 6'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign busy = (cnt != 6'd0);

  // Bubbles carry arbitrary order bits, so only valid groups can flag a conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_err <= 1'b0;
    end else if (ord_valid && map_conflict) begin
      map_err <= 1'b1;
    end
  end

endmodule

// File: doc/ntt_wb_mapper.md
# ntt_wb_mapper

Write-back address mapper for the radix-16 memory-based NTT datapath. It receives the 16 per-cycle coefficient orders issued by the read-side address generator. It maps each order to a conflict-free memory bank and an in-bank address, then delays the resulting write commands by the butterfly pipeline latency so that PE results are written back to the locations they were read from. It sits between the address generator and the 16 single-port coefficient banks and drives the write ports and the lane-to-bank data crossbar select.

## Interface
- D_WIDTH, 12: order width (log2 n); must be a multiple of 4.
- PE_LAT, 8: cycles from read-order issue to PE result valid; legal range 2..32.
- BANKS, 16: number of banks and lanes; fixed at 16 (radix-16).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ord_valid  in  1  order group valid (address generator output enable).
- ord  in  16*D_WIDTH  lane k order at bits [k*D_WIDTH +: D_WIDTH].
- stage_in  in  3  NTT stage index of the group.
- agu_done  in  1  single-cycle pulse: last group of the transform issued.
- wb_valid  out  1  write group valid; all 16 banks write.
- wb_addr  out  16*(D_WIDTH-4)  bank b in-bank address at [b*(D_WIDTH-4) +: D_WIDTH-4].
- wb_sel  out  16*4  bank b source lane index.
- wb_stage  out  3  stage index of the write group.
- wb_done  out  1  pulse: last write group of the transform.
- busy  out  1  at least one group in flight.
- map_err  out  1  sticky: two lanes of one group mapped to the same bank.

## Operation
- Bank mapping: bank(x) = (sum of the 4-bit digits of x) mod 16; in-bank address = x >> 4.
- Routing: for each bank b, wb_sel[b] = lane k with bank(ord[k]) == b; wb_addr[b] = ord[k] >> 4.
- Conflict (two lanes share a bank): lowest lane index wins; map_err set, cleared only by rst.
- Empty bank (occurs only with a conflict): wb_sel = 0, wb_addr = 0.
- Mapping is computed and registered in stage M1. A delay line of PE_LAT-1 further registers carries {valid, addr, sel, stage, done}.
- Groups with ord_valid = 0 enter as bubbles. Their addr/sel content is don't-care, but wb_valid must be 0.
- No backpressure: banks always accept. ord_valid deasserting does not flush the line; in-flight groups drain.
- agu_done travels the delay line independently of ord_valid.
- In-flight counter, width 6: +1 on ord_valid, -1 on wb_valid; both in one cycle leaves it unchanged. busy = (count != 0).

## Timing
- ord_valid sampled high at edge t produces wb_valid high in the cycle after edge t+PE_LAT-1. Latency is exactly PE_LAT cycles, matching the PE pipeline.
- wb_done follows agu_done with the same latency, aligned to the group sampled in the same cycle.
- Back-to-back groups give back-to-back wb_valid, at throughput 1 group/cycle.
- Reset values: wb_valid 0, wb_addr 0, wb_sel 0, wb_stage 0, wb_done 0, busy 0, map_err 0.
- Reset mid-operation clears the delay line and counter immediately. No write from pre-reset groups may appear after rst deasserts.
- map_err rises in the cycle after the offending group is sampled (M1 output), not PE_LAT later.

## Structure
- ntt_pkg holds: BANKS, LANE_W = 4, D_WIDTH default, and function bank_of(order) (digit-sum mod 16).
- Sub-module ntt_bank_map: combinational 16-lane bank/address compute plus bank-indexed priority select. Instantiated once and registered in M1 by the top.
- The top holds the M1 register, the parameterised delay line (generate loop), the counter and map_err.

## Test plan
- D_WIDTH=12, PE_LAT=4; stage 0, ord[k] = k*256 with ord_valid for 1 cycle -> 4 cycles later wb_valid=1, wb_sel[b]=b, wb_addr[b]=b*16, wb_stage=0; busy=1 for 4 cycles, then 0.
- Same setup, ord[k] = 1 + k*256 -> wb_sel[0]=15, wb_addr[0]=240; wb_sel[1]=0, wb_addr[1]=0; no map_err.
- Stage 1, ord[k] = 0x300 + 16*k -> wb_sel[3]=0, wb_addr[3]=0x30; wb_sel[2]=15, wb_addr[2]=0x3F; wb_stage=1.
- 20 back-to-back groups, then agu_done pulsed with the last one -> 20 consecutive wb_valid cycles; wb_done high only in the 20th.
- ord[0] = ord[1] = 5 -> map_err=1 in the next cycle and stays 1; bank 5 gets wb_sel=0.
- rst asserted with 3 groups in flight -> wb_valid, busy and counter 0 immediately; no wb_valid after release; map_err cleared.
